// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch FSM state encoding.
package cpu_pkg;

  localparam int DEFAULT_PC_W    = 16;
  localparam int DEFAULT_INSTR_W = 16;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2,
    HALT    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_seq_pc_reg.sv
// Program counter register with a single write port.
// The reset is synchronous, and RESET_PC sets the reset value.
module pc_reg #(
  parameter int              PC_W     = cpu_pkg::DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_we_i,
  input  logic [PC_W-1:0] pc_next_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (pc_we_i) begin
      pc_q <= pc_next_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer. It keeps at most one request outstanding and hands instructions to decode.
// When a redirect lands while a fetch is in flight, the fetch is marked for discard.
module fetch_seq #(
  parameter int              PC_W     = cpu_pkg::DEFAULT_PC_W,
  parameter int              INSTR_W  = cpu_pkg::DEFAULT_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               busy
);

  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic               discard_q, discard_d;
  logic               instr_valid_q, instr_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic               capture;
  logic               pc_we;
  logic [PC_W-1:0]    pc_next;
  logic [PC_W-1:0]    pc;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .pc_we_i   (pc_we),
    .pc_next_i (pc_next),
    .pc_o      (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    capture       = 1'b0;
    case (state_q)
      FETCH: begin
        // A redirect in the same cycle as a grant poisons the returning data.
        if (imem_gnt) begin
          state_d   = WAIT;
          discard_d = redirect;
        end else if (halt) begin
          state_d = HALT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect || discard_q) begin
            discard_d = 1'b0;
            state_d   = FETCH;
          end else begin
            capture       = 1'b1;
            instr_d       = imem_rdata;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            state_d       = DELIVER;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      DELIVER: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = halt ? HALT : FETCH;
        end
      end
      HALT: begin
        if (!halt) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign pc_we   = redirect | capture;
  assign pc_next = redirect ? redirect_pc : pc + {{(PC_W-1){1'b0}}, 1'b1};

  // The request is held low while reset is asserted, so it rises only in the first cycle after reset.
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = pc;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = (state_q != HALT);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed testbench for fetch_seq. Inputs are driven on the falling edge and outputs are checked 1 time unit later.
module tb_fetch_seq;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [15:0] rdata;
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        hlt;
    logic        eReq;
    logic [15:0] eAddr;
    logic        eValid;
    logic [15:0] eInstr;
    logic [15:0] ePc;
    logic        eBusy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fetch_seq #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic gnt, input logic rv, input logic [15:0] rdata,
                              input logic rdy, input logic redir, input logic [15:0] rpc, input logic hlt,
                              input logic eReq, input logic [15:0] eAddr, input logic eValid,
                              input logic [15:0] eInstr, input logic [15:0] ePc, input logic eBusy);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
    v.redir = redir; v.rpc = rpc; v.hlt = hlt;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.ePc = ePc; v.eBusy = eBusy;
    return v;
  endfunction

  task automatic checkField(input string name, input string field, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    checkField(name, "imem_req",    {15'd0, imem_req},    {15'd0, v.eReq});
    checkField(name, "imem_addr",   imem_addr,            v.eAddr);
    checkField(name, "instr_valid", {15'd0, instr_valid}, {15'd0, v.eValid});
    checkField(name, "instr",       instr,                v.eInstr);
    checkField(name, "instr_pc",    instr_pc,             v.ePc);
    checkField(name, "busy",        {15'd0, busy},        {15'd0, v.eBusy});
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    @(negedge clk);
    reset       = v.rst;
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    instr_ready = v.rdy;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    halt        = v.hlt;
    #1;
    checkOutput(name, v);
  endtask

  vec_t vecs[29];

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(posedge clk);
    @(posedge clk);

    //             rst gnt rv rdata    rdy rdr rpc      hlt | req addr     vld instr    ipc      busy
    vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    vecs[1]  = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    vecs[2]  = mk(0, 0, 1, 16'h1234, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    vecs[3]  = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0001, 1, 16'h1234, 16'h0000, 1);
    vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 1, 16'h0005, 0,   1, 16'h0001, 0, 16'h1234, 16'h0000, 1);
    vecs[5]  = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0040, 0,   1, 16'h0005, 0, 16'h1234, 16'h0000, 1);
    vecs[6]  = mk(0, 0, 1, 16'hDEAD, 0, 0, 16'h0000, 0,   0, 16'h0040, 0, 16'h1234, 16'h0000, 1);
    vecs[7]  = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0040, 0, 16'h1234, 16'h0000, 1);
    vecs[8]  = mk(0, 0, 1, 16'hBEEF, 0, 0, 16'h0000, 0,   0, 16'h0040, 0, 16'h1234, 16'h0000, 1);
    vecs[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0041, 1, 16'hBEEF, 16'h0040, 1);
    vecs[10] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0041, 1, 16'hBEEF, 16'h0040, 1);
    vecs[11] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0041, 1, 16'hBEEF, 16'h0040, 1);
    vecs[12] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0041, 1, 16'hBEEF, 16'h0040, 1);
    vecs[13] = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0041, 1, 16'hBEEF, 16'h0040, 1);
    vecs[14] = mk(0, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 0,   1, 16'h0041, 0, 16'hBEEF, 16'h0040, 1);
    vecs[15] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'hFFFF, 0, 16'hBEEF, 16'h0040, 1);
    vecs[16] = mk(0, 0, 1, 16'h0F0F, 0, 0, 16'h0000, 0,   0, 16'hFFFF, 0, 16'hBEEF, 16'h0040, 1);
    vecs[17] = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0000, 1, 16'h0F0F, 16'hFFFF, 1);
    vecs[18] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0F0F, 16'hFFFF, 1);
    vecs[19] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 16'h0F0F, 16'hFFFF, 1);
    vecs[20] = mk(0, 0, 1, 16'h5555, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 16'h0F0F, 16'hFFFF, 1);
    vecs[21] = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1,   0, 16'h0001, 1, 16'h5555, 16'h0000, 1);
    vecs[22] = mk(0, 0, 0, 16'h0000, 0, 1, 16'h0100, 1,   0, 16'h0001, 0, 16'h5555, 16'h0000, 0);
    vecs[23] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0100, 0, 16'h5555, 16'h0000, 0);
    vecs[24] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0100, 0, 16'h5555, 16'h0000, 1);
    vecs[25] = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0100, 0, 16'h5555, 16'h0000, 1);
    vecs[26] = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    vecs[27] = mk(0, 0, 1, 16'h7777, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000, 1);
    vecs[28] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000, 1);

    for (int i = 0; i < 29; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Redirect in the same cycle as rvalid: the redirect wins and the data is dropped.
    applyStimulus("rdrRv_gnt",  mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 1));
    applyStimulus("rdrRv_hit",  mk(0, 0, 1, 16'h9999, 0, 1, 16'h0200, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));
    applyStimulus("rdrRv_post", mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0200, 0, 16'h0000, 16'h0000, 1));

    // Redirect in DELIVER while instr_ready is low still drops instr_valid.
    applyStimulus("dlvRdr_rv",   mk(0, 0, 1, 16'hAAAA, 0, 0, 16'h0000, 0, 0, 16'h0200, 0, 16'h0000, 16'h0000, 1));
    applyStimulus("dlvRdr_hit",  mk(0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 0, 16'h0201, 1, 16'hAAAA, 16'h0200, 1));
    applyStimulus("dlvRdr_post", mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'hAAAA, 16'h0200, 1));

    // Two redirects in WAIT: the last target is kept, and the late data is dropped.
    applyStimulus("dblRdr_1",    mk(0, 0, 0, 16'h0000, 0, 1, 16'h0400, 0, 0, 16'h0300, 0, 16'hAAAA, 16'h0200, 1));
    applyStimulus("dblRdr_2",    mk(0, 0, 0, 16'h0000, 0, 1, 16'h0500, 0, 0, 16'h0400, 0, 16'hAAAA, 16'h0200, 1));
    applyStimulus("dblRdr_rv",   mk(0, 0, 1, 16'hBBBB, 0, 0, 16'h0000, 0, 0, 16'h0500, 0, 16'hAAAA, 16'h0200, 1));
    applyStimulus("dblRdr_post", mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0500, 0, 16'hAAAA, 16'h0200, 1));

    // Halt in FETCH without a grant goes straight to HALT, then resumes.
    applyStimulus("fHalt_req",  mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 16'h0500, 0, 16'hAAAA, 16'h0200, 1));
    applyStimulus("fHalt_halt", mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0500, 0, 16'hAAAA, 16'h0200, 0));
    applyStimulus("fHalt_run",  mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0500, 0, 16'hAAAA, 16'h0200, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
